// File: rtl/a2d_scan_ctrl_if.sv
// Link between the scan sequencer and the 16-bit SPI master:
// launch pulse and command out, completion level and readback in.
interface a2d_scan_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );
endinterface

// File: rtl/a2d_scan_ctrl.sv
// A2D conversion sequencer: two SPI transactions per conversion,
// periodic auto-scan of all channels plus a priority one-shot port.
module a2d_scan_ctrl #(
    parameter int NUM_CHNL    = 4,
    parameter int SCAN_PERIOD = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   strt_cnv,
    input  logic [2:0]             chnnl,
    output logic                   cnv_cmplt,
    output logic [11:0]            res,
    output logic [12*NUM_CHNL-1:0] res_all,
    output logic                   scan_vld,
    a2d_scan_ctrl_if.master        spi
);
    localparam int PW = $clog2(SCAN_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        GAP,
        TX2,
        STORE
    } state_t;

    state_t        state;
    logic [PW-1:0] per_cnt;
    logic          done_q;
    logic          done_rise;
    logic          wrap;
    logic          os_pend;
    logic [2:0]    os_ch;
    logic          cur_os;
    logic          sw_act;
    logic [2:0]    sw_idx;
    logic [11:0]   rslt;

    assign done_rise = spi.done & ~done_q;
    assign wrap      = (per_cnt == PW'(SCAN_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            per_cnt   <= '0;
            done_q    <= 1'b0;
            os_pend   <= 1'b0;
            os_ch     <= '0;
            cur_os    <= 1'b0;
            sw_act    <= 1'b0;
            sw_idx    <= '0;
            rslt      <= '0;
            cnv_cmplt <= 1'b0;
            res       <= '0;
            res_all   <= '0;
            scan_vld  <= 1'b0;
            spi.wrt   <= 1'b0;
            spi.cmd   <= '0;
        end else begin
            done_q   <= spi.done;
            spi.wrt  <= 1'b0;
            scan_vld <= 1'b0;
            per_cnt  <= wrap ? '0 : per_cnt + 1'b1;

            // A wrap during an active sweep is simply dropped.
            if (wrap && !sw_act) begin
                sw_act <= 1'b1;
                sw_idx <= '0;
            end

            if (strt_cnv) begin
                os_pend   <= 1'b1;
                os_ch     <= chnnl;
                cnv_cmplt <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (os_pend) begin
                        spi.wrt <= 1'b1;
                        spi.cmd <= {2'b00, os_ch, 11'h000};
                        cur_os  <= 1'b1;
                        state   <= TX1;
                        if (!strt_cnv)
                            os_pend <= 1'b0;
                    end else if (sw_act) begin
                        spi.wrt <= 1'b1;
                        spi.cmd <= {2'b00, sw_idx, 11'h000};
                        cur_os  <= 1'b0;
                        state   <= TX1;
                    end
                end
                TX1: begin
                    if (done_rise)
                        state <= GAP;
                end
                GAP: begin
                    spi.wrt <= 1'b1;
                    state   <= TX2;
                end
                TX2: begin
                    if (done_rise) begin
                        rslt  <= spi.rd_data[11:0];
                        state <= STORE;
                    end
                end
                STORE: begin
                    state <= IDLE;
                    if (cur_os) begin
                        res <= rslt;
                        if (!strt_cnv)
                            cnv_cmplt <= 1'b1;
                    end else begin
                        for (int k = 0; k < NUM_CHNL; k++)
                            if (sw_idx == 3'(k))
                                res_all[12*k +: 12] <= rslt;
                        if (sw_idx == 3'(NUM_CHNL - 1)) begin
                            sw_act   <= 1'b0;
                            scan_vld <= 1'b1;
                        end else begin
                            sw_idx <= sw_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Bench for a2d_scan_ctrl: SPI slave model with per-channel replies,
// one-shot vector table, scan/interleave/reset sequences, random soak.
module tb_a2d_scan_ctrl;
    localparam int NCH = 4;
    localparam int PER = 64;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              strt_cnv = 1'b0;
    logic [2:0]        chnnl    = 3'd0;
    logic              cnv_cmplt;
    logic [11:0]       res;
    logic [12*NCH-1:0] res_all;
    logic              scan_vld;

    a2d_scan_ctrl_if spi();

    a2d_scan_ctrl #(
        .NUM_CHNL   (NCH),
        .SCAN_PERIOD(PER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .res_all  (res_all),
        .scan_vld (scan_vld),
        .spi      (spi)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // SPI slave model: per-channel result table, transaction log
    logic [11:0] val_tbl [8];
    bit          stale    = 1'b0;
    bit          lat_rand = 1'b0;
    bit          rnd_on   = 1'b0;
    int          rnd_sweeps = 0;
    int          lat;
    int          cnt;
    bit          busy;
    bit          second;
    bit          parity;
    logic [15:0] cur_cmd;
    logic [15:0] first_cmd;
    logic [15:0] prev_cmd;
    int          viol = 0;
    int          nwrt = 0;
    logic [15:0] log_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi.done    <= 1'b0;
            spi.rd_data <= '0;
            busy        <= 1'b0;
            cnt         <= 0;
            lat         <= 2;
            second      <= 1'b0;
            parity      <= 1'b0;
            cur_cmd     <= '0;
            first_cmd   <= '0;
            prev_cmd    <= '0;
        end else begin
            prev_cmd <= spi.cmd;
            if (!spi.wrt && spi.cmd !== prev_cmd)
                viol++;
            if (spi.wrt) begin
                if (busy)
                    viol++;
                if (spi.cmd[15:14] != 2'b00 || spi.cmd[10:0] != 11'h000)
                    viol++;
                nwrt++;
                busy    <= 1'b1;
                cnt     <= 0;
                cur_cmd <= spi.cmd;
                second  <= parity;
                parity  <= ~parity;
                lat     <= lat_rand ? int'($urandom_range(6, 2)) : 2;
                if (!stale)
                    spi.done <= 1'b0;
                if (parity) begin
                    if (spi.cmd != first_cmd)
                        viol++;
                    log_q.push_back(spi.cmd);
                end else begin
                    first_cmd <= spi.cmd;
                end
            end else if (busy) begin
                cnt <= cnt + 1;
                if (cnt == 1)
                    spi.done <= 1'b0;
                if (cnt == lat) begin
                    spi.done <= 1'b1;
                    busy     <= 1'b0;
                    spi.rd_data <= second ?
                        {4'h0, val_tbl[cur_cmd[13:11]]} :
                        {4'hF, ~val_tbl[cur_cmd[13:11]]};
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        strt_cnv = 1'b0;
        rst_n    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic start(logic [2:0] ch);
        chnnl    = ch;
        strt_cnv = 1'b1;
        tick();
        strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt(int budget);
        int n = 0;
        while (!cnv_cmplt && n < budget) begin
            tick();
            n++;
        end
        if (!cnv_cmplt) begin
            tests++;
            fails++;
            $display("FAIL cmplt_timeout: cnv_cmplt=0 after %0d cycles, want 1", budget);
        end
    endtask

    task automatic wait_scan(int budget);
        int n = 0;
        while (!scan_vld && n < budget) begin
            tick();
            n++;
        end
        if (!scan_vld) begin
            tests++;
            fails++;
            $display("FAIL scan_timeout: scan_vld=0 after %0d cycles, want 1", budget);
        end
    endtask

    task automatic wait_wrt(logic [15:0] c, int budget);
        int n = 0;
        while (!(spi.wrt && spi.cmd == c) && n < budget) begin
            tick();
            n++;
        end
        if (!(spi.wrt && spi.cmd == c)) begin
            tests++;
            fails++;
            $display("FAIL wrt_timeout: no wrt with cmd %0h in %0d cycles", c, budget);
        end
    endtask

    // Channel order of completed conversions, one nibble (ch+1) each
    function automatic logic [31:0] seq_code();
        logic [31:0] code = '0;
        foreach (log_q[i])
            code = (code << 4) | 32'(log_q[i][13:11] + 3'd0) + 32'd1;
        return code;
    endfunction

    function automatic logic [12*NCH-1:0] bank_exp();
        logic [12*NCH-1:0] b = '0;
        for (int k = 0; k < NCH; k++)
            b[12*k +: 12] = val_tbl[k];
        return b;
    endfunction

    always @(negedge clk) begin
        if (rnd_on && scan_vld) begin
            rnd_sweeps++;
            check("rnd_bank", res_all, bank_exp());
        end
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        logic [15:0] exp_cmd;
        logic [11:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   w0;
        int   n0;
        int   rises;
        bit   prev_c;
        logic [2:0] rch;
        time  t0;

        vecs[0] = '{3'd3, 12'hABC, 16'h1800, 12'hABC};
        vecs[1] = '{3'd0, 12'h5A5, 16'h0000, 12'h5A5};
        vecs[2] = '{3'd7, 12'hFFF, 16'h3800, 12'hFFF};
        vecs[3] = '{3'd6, 12'h001, 16'h3000, 12'h001};
        vecs[4] = '{3'd1, 12'h800, 16'h0800, 12'h800};
        vecs[5] = '{3'd4, 12'h7E1, 16'h2000, 12'h7E1};
        for (int k = 0; k < 8; k++)
            val_tbl[k] = 12'h100 + 12'(k);

        // One-shot vectors, each from a fresh reset
        foreach (vecs[i]) begin
            do_reset();
            log_q.delete();
            check("rst_outs", {cnv_cmplt, scan_vld, spi.wrt, res, spi.cmd}, '0);
            check("rst_bank", res_all, '0);
            val_tbl[vecs[i].ch] = vecs[i].val;
            w0 = nwrt;
            start(vecs[i].ch);
            wait_cmplt(60);
            check("os_res", res, vecs[i].exp_res);
            check("os_cmd", (log_q.size() == 1) ? log_q[0] : 16'hFFFF, vecs[i].exp_cmd);
            tick(10);
            check("os_hold", cnv_cmplt, 1'b1);
            check("os_nwrt", nwrt - w0, 2);
        end

        // Auto-scan bank and period
        for (int k = 0; k < 8; k++)
            val_tbl[k] = 12'h100 + 12'(k);
        do_reset();
        log_q.delete();
        wait_scan(200);
        t0 = $time;
        check("scan_bank", res_all, 48'h103102101100);
        check("scan_order", seq_code(), 32'h1234);
        tick();
        check("scan_pulse", scan_vld, 1'b0);
        wait_scan(100);
        check("scan_period", ($time - t0) / 10, PER);
        n0 = 0;
        for (int c = 0; c < 3 * PER; c++) begin
            tick();
            if (scan_vld)
                n0++;
        end
        check("scan_count", n0, 3);

        // One-shot ch6 injected during TX1 of auto channel 1
        val_tbl[6] = 12'h666;
        do_reset();
        log_q.delete();
        wait_wrt(16'h0800, 200);
        start(3'd6);
        wait_scan(300);
        check("ilv_order", seq_code(), 32'h12734);
        check("ilv_bank", res_all, 48'h103102101100);
        check("ilv_cmplt", cnv_cmplt, 1'b1);
        check("ilv_res", res, 12'h666);

        // Second request overwrites the pending one
        do_reset();
        log_q.delete();
        wait_wrt(16'h0000, 200);
        start(3'd5);
        tick();
        start(3'd2);
        rises  = 0;
        prev_c = cnv_cmplt;
        n0     = 0;
        while (!scan_vld && n0 < 300) begin
            tick();
            n0++;
            if (cnv_cmplt && !prev_c)
                rises++;
            prev_c = cnv_cmplt;
        end
        check("ovw_order", seq_code(), 32'h13234);
        check("ovw_rises", rises, 1);
        check("ovw_res", res, 12'h102);
        start(3'd3);
        check("cmplt_clr", cnv_cmplt, 1'b0);
        wait_cmplt(80);
        check("clr_res", res, 12'h103);

        // Stale done level held across wrt
        stale = 1'b1;
        val_tbl[5] = 12'h5C3;
        val_tbl[1] = 12'h3A1;
        do_reset();
        w0 = nwrt;
        start(3'd5);
        wait_cmplt(80);
        check("stale_res5", res, 12'h5C3);
        start(3'd1);
        wait_cmplt(80);
        check("stale_res1", res, 12'h3A1);
        check("stale_nwrt", nwrt - w0, 4);
        stale = 1'b0;

        // Async reset during TX2
        do_reset();
        wait_scan(200);
        log_q.delete();
        start(3'd2);
        n0 = 0;
        while (log_q.size() == 0 && n0 < 60) begin
            tick();
            n0++;
        end
        check("tx2_reached", log_q.size(), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_outs", {cnv_cmplt, scan_vld, spi.wrt, res, spi.cmd}, '0);
        check("arst_bank", res_all, '0);
        tick();
        rst_n = 1'b1;
        w0 = nwrt;
        tick(50);
        check("arst_quiet", nwrt - w0, 0);
        check("arst_cmplt", cnv_cmplt, 1'b0);

        // Random one-shots over a running auto-scan
        for (int k = 0; k < 8; k++)
            val_tbl[k] = 12'($urandom);
        lat_rand = 1'b1;
        do_reset();
        rnd_on = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick($urandom_range(0, 40));
            rch = 3'($urandom_range(0, 7));
            start(rch);
            check("rnd_clr", cnv_cmplt, 1'b0);
            wait_cmplt(200);
            check("rnd_res", res, val_tbl[rch]);
        end
        tick(200);
        rnd_on = 1'b0;
        check("rnd_sweeps", rnd_sweeps > 2, 1'b1);
        check("protocol_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
